garage_input_conditioner: RTL and testbench

Front-end conditioning stage for the automatic garage door controller. Takes the raw, asynchronous, bouncy push-button and limit-switch inputs, synchronises and debounces each, and drives the controller's `Activate`, `Up_Max` and `DN_Max` inputs. `Activate` is reduced to a single-cycle pulse per press, so a held button cannot re-trigger the door. Also flags the physically impossible "both limits active" condition.

---
 rtl/garage_pkg.sv | 12 +
 rtl/debounce_channel.sv | 57 +++++
 rtl/garage_input_conditioner.sv | 85 ++++++++
 tb/tb_garage_input_conditioner.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/garage_pkg.sv
// Purpose: shared defaults for the garage door input front end and the controller top level.
// Latency: n/a (constants only).
// Backpressure: n/a.
package garage_pkg;

    // Consecutive stable synchronised cycles needed before a new input level is accepted.
    localparam int GARAGE_DEBOUNCE_CYCLES = 16;

    // Synchroniser depth applied to every raw asynchronous input.
    localparam int GARAGE_SYNC_STAGES     = 2;

endpackage : garage_pkg

// File: rtl/debounce_channel.sv
// Purpose: synchronise one raw asynchronous input and debounce it into a stable level.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from the first sampling edge to level_out.
// Backpressure: none; free-running, one sample per clock.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   raw_in    - raw asynchronous input
//   level_out - debounced level (registered)
module debounce_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   stable_q;
    logic [CW-1:0]          cnt_q;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    // The counter measures how long sync has disagreed with the accepted level;
    // any agreement restarts it, so only an uninterrupted run of DEBOUNCE_CYCLES
    // disagreeing samples moves the stable level. It saturates by construction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else if (sync == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_q <= sync;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level_out = stable_q;

endmodule : debounce_channel

// File: rtl/garage_input_conditioner.sv
// Purpose: condition raw button/limit inputs for the garage controller; one pulse per press, fault flag.
// Latency: limits SYNC_STAGES+DEBOUNCE_CYCLES edges, Activate pulse one edge later.
// Backpressure: none; Activate is a fire-and-forget single-cycle pulse.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-low reset
//   Activate_Raw - raw push-button, active high
//   Up_Max_Raw   - raw fully-open limit switch
//   DN_Max_Raw   - raw fully-closed limit switch
//   Activate     - one-cycle pulse per debounced press (suppressed during sensor fault)
//   Up_Max       - debounced fully-open level
//   DN_Max       - debounced fully-closed level
//   Sensor_Fault - both debounced limits active at once
module garage_input_conditioner
    import garage_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = GARAGE_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = GARAGE_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic Activate_Raw,
    input  logic Up_Max_Raw,
    input  logic DN_Max_Raw,
    output logic Activate,
    output logic Up_Max,
    output logic DN_Max,
    output logic Sensor_Fault
);

    logic act_level;
    logic act_level_d;
    logic act_pulse_q;

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_act_chan (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (Activate_Raw),
        .level_out (act_level)
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_up_chan (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (Up_Max_Raw),
        .level_out (Up_Max)
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dn_chan (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (DN_Max_Raw),
        .level_out (DN_Max)
    );

    // Both limits closed cannot happen on a healthy door; Up_Max/DN_Max are
    // already register outputs, so this stays glitch-free.
    assign Sensor_Fault = Up_Max & DN_Max;

    // Rising-edge detect on the debounced button. A press seen while the limit
    // sensors disagree with physics is dropped outright rather than held over,
    // so a stale press cannot move the door once the fault clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_level_d <= 1'b0;
            act_pulse_q <= 1'b0;
        end else begin
            act_level_d <= act_level;
            act_pulse_q <= act_level & ~act_level_d & ~Sensor_Fault;
        end
    end

    assign Activate = act_pulse_q;

endmodule : garage_input_conditioner

// File: tb/tb_garage_input_conditioner.sv
module tb_garage_input_conditioner;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + DEB;   // level latency in edges

    typedef struct packed {
        logic act;
        logic up;
        logic dn;
        logic flt;
    } exp_t;

    logic clk;
    logic rst;
    logic Activate_Raw;
    logic Up_Max_Raw;
    logic DN_Max_Raw;
    logic Activate;
    logic Up_Max;
    logic DN_Max;
    logic Sensor_Fault;

    int compared   = 0;
    int mismatched = 0;

    exp_t exp_q[$];

    garage_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Activate_Raw (Activate_Raw),
        .Up_Max_Raw   (Up_Max_Raw),
        .DN_Max_Raw   (DN_Max_Raw),
        .Activate     (Activate),
        .Up_Max       (Up_Max),
        .DN_Max       (DN_Max),
        .Sensor_Fault (Sensor_Fault)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_bit(input string tag, input int cyc, input logic obs, input logic expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    // Queue the expected outputs for the coming edge, let the edge happen, then
    // pop and compare on the falling edge.
    task automatic cyc(input string tag, input int k, input logic a, input logic u,
                       input logic d, input logic f);
        exp_t e;
        e.act = a; e.up = u; e.dn = d; e.flt = f;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s cycle %0d: scoreboard empty, observed none expected entry", tag, k);
        end else begin
            e = exp_q.pop_front();
            check_bit({tag, ".Activate"},     k, Activate,     e.act);
            check_bit({tag, ".Up_Max"},       k, Up_Max,       e.up);
            check_bit({tag, ".DN_Max"},       k, DN_Max,       e.dn);
            check_bit({tag, ".Sensor_Fault"}, k, Sensor_Fault, e.flt);
        end
    endtask

    initial begin
        // Reset held with every raw input high: nothing may leak through.
        rst = 1'b0; Activate_Raw = 1'b1; Up_Max_Raw = 1'b1; DN_Max_Raw = 1'b1;
        for (int k = 1; k <= 10; k++) cyc("reset", k, 0, 0, 0, 0);
        Activate_Raw = 1'b0; Up_Max_Raw = 1'b0; DN_Max_Raw = 1'b0;
        cyc("reset_lo", 1, 0, 0, 0, 0);
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) cyc("idle", k, 0, 0, 0, 0);

        // Clean press held for 20 cycles: one pulse on edge LAT+1, none on release.
        Activate_Raw = 1'b1;
        for (int k = 1; k <= 20; k++) cyc("press", k, (k == LAT + 1), 0, 0, 0);
        Activate_Raw = 1'b0;
        for (int k = 1; k <= 10; k++) cyc("release", k, 0, 0, 0, 0);

        // Bounce: high 2 / low 1 three times, then low.
        for (int r = 0; r < 3; r++) begin
            Activate_Raw = 1'b1; cyc("bounce", 3*r+1, 0, 0, 0, 0);
            cyc("bounce", 3*r+2, 0, 0, 0, 0);
            Activate_Raw = 1'b0; cyc("bounce", 3*r+3, 0, 0, 0, 0);
        end
        for (int k = 1; k <= 6; k++) cyc("bounce_lo", k, 0, 0, 0, 0);
        Activate_Raw = 1'b1;
        for (int k = 1; k <= 8; k++) cyc("bounce_hold", k, (k == LAT + 1), 0, 0, 0);
        Activate_Raw = 1'b0;
        for (int k = 1; k <= 8; k++) cyc("bounce_rel", k, 0, 0, 0, 0);

        // Fully-closed switch: bring it high, then 1->0, then a short high glitch.
        DN_Max_Raw = 1'b1;
        for (int k = 1; k <= 8; k++) cyc("dn_rise", k, 0, 0, (k >= LAT), 0);
        DN_Max_Raw = 1'b0;
        for (int k = 1; k <= 8; k++) cyc("dn_fall", k, 0, 0, (k < LAT), 0);
        DN_Max_Raw = 1'b1;
        for (int k = 1; k <= 3; k++) cyc("dn_glitch", k, 0, 0, 0, 0);
        DN_Max_Raw = 1'b0;
        for (int k = 1; k <= 8; k++) cyc("dn_glitch_lo", k, 0, 0, 0, 0);

        // Both limits active: fault from edge LAT, press suppressed and not deferred.
        Up_Max_Raw = 1'b1; DN_Max_Raw = 1'b1;
        for (int k = 1; k <= 8; k++) cyc("fault", k, 0, (k >= LAT), (k >= LAT), (k >= LAT));
        Activate_Raw = 1'b1;
        for (int k = 1; k <= 10; k++) cyc("fault_press", k, 0, 1, 1, 1);
        Activate_Raw = 1'b0;
        for (int k = 1; k <= 8; k++) cyc("fault_rel", k, 0, 1, 1, 1);
        Up_Max_Raw = 1'b0; DN_Max_Raw = 1'b0;
        for (int k = 1; k <= 8; k++) cyc("fault_clr", k, 0, (k < LAT), (k < LAT), (k < LAT));

        // Reset part-way through a count: the full count restarts after release.
        Up_Max_Raw = 1'b1;
        for (int k = 1; k <= 4; k++) cyc("up_pre", k, 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 1; k <= 2; k++) cyc("up_rst", k, 0, 0, 0, 0);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) cyc("up_post", k, 0, (k >= LAT), 0, 0);

        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_garage_input_conditioner
